// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
// Shift-add multiply and restoring divide on magnitudes; signs are restored in one FIX cycle.
module muldiv_unit #(
    parameter int unsigned WIDTH    = 32,
    parameter logic [5:0]  F_MULT   = 6'h18,
    parameter logic [5:0]  F_MULTU  = 6'h19,
    parameter logic [5:0]  F_DIV    = 6'h1A,
    parameter logic [5:0]  F_DIVU   = 6'h1B,
    parameter logic [5:0]  F_MTHI   = 6'h11,
    parameter logic [5:0]  F_MTLO   = 6'h13
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Start,
    input  logic [5:0]       Funct,
    input  logic [WIDTH-1:0] Rdata1,
    input  logic [WIDTH-1:0] Rdata2,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [2:0] {StIdle, StMul, StDiv, StFix, StDone} state_e;

    state_e               state_q;
    logic [CntW-1:0]      cnt_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]     opb_q;
    logic                 is_div_q;
    logic                 div0_q;
    logic                 neg_res_q;
    logic                 neg_rem_q;

    logic                 is_mul, is_div, is_signed;
    logic                 a_neg, b_neg;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       div_shift, div_diff;
    logic [2*WIDTH-1:0]   div_next;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix, rem_fix;
    logic [WIDTH-1:0]     fix_hi, fix_lo;

    always_comb begin
        is_mul    = (Funct == F_MULT) || (Funct == F_MULTU);
        is_div    = (Funct == F_DIV) || (Funct == F_DIVU);
        is_signed = (Funct == F_MULT) || (Funct == F_DIV);
        a_neg     = is_signed & Rdata1[WIDTH-1];
        b_neg     = is_signed & Rdata2[WIDTH-1];
        a_mag     = a_neg ? -Rdata1 : Rdata1;
        b_mag     = b_neg ? -Rdata2 : Rdata2;
    end

    // acc_q holds {upper partial product, multiplier} for MUL and {remainder, quotient} for DIV.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
        div_shift = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff  = div_shift - {1'b0, opb_q};
        div_next  = {(div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0]),
                     acc_q[WIDTH-2:0], ~div_diff[WIDTH]};
    end

    always_comb begin
        prod_fix = neg_res_q ? -acc_q : acc_q;
        quo_fix  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        if (is_div_q) begin
            fix_hi = rem_fix;
            fix_lo = div0_q ? '1 : quo_fix;
        end else begin
            fix_hi = prod_fix[2*WIDTH-1:WIDTH];
            fix_lo = prod_fix[WIDTH-1:0];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            acc_q     <= '0;
            opb_q     <= '0;
            is_div_q  <= 1'b0;
            div0_q    <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Hi        <= '0;
            Lo        <= '0;
        end else begin
            Done <= 1'b0;
            unique case (state_q)
                StIdle, StDone: begin
                    state_q <= StIdle;
                    if (Start && is_mul) begin
                        acc_q     <= {{WIDTH{1'b0}}, b_mag};
                        opb_q     <= a_mag;
                        cnt_q     <= '0;
                        is_div_q  <= 1'b0;
                        div0_q    <= 1'b0;
                        neg_res_q <= a_neg ^ b_neg;
                        neg_rem_q <= 1'b0;
                        Busy      <= 1'b1;
                        state_q   <= StMul;
                    end else if (Start && is_div) begin
                        opb_q     <= b_mag;
                        cnt_q     <= '0;
                        is_div_q  <= 1'b1;
                        neg_res_q <= a_neg ^ b_neg;
                        neg_rem_q <= a_neg;
                        Busy      <= 1'b1;
                        // Divide by zero parks the dividend in the remainder half so FIX returns it.
                        if (Rdata2 == '0) begin
                            div0_q  <= 1'b1;
                            acc_q   <= {a_mag, {WIDTH{1'b0}}};
                            state_q <= StFix;
                        end else begin
                            div0_q  <= 1'b0;
                            acc_q   <= {{WIDTH{1'b0}}, a_mag};
                            state_q <= StDiv;
                        end
                    end else if (Start && (Funct == F_MTHI)) begin
                        Hi <= Rdata1;
                    end else if (Start && (Funct == F_MTLO)) begin
                        Lo <= Rdata1;
                    end
                end
                StMul: begin
                    acc_q <= mul_next;
                    cnt_q <= cnt_q + CntW'(1);
                    if (cnt_q == CntW'(WIDTH - 1)) state_q <= StFix;
                end
                StDiv: begin
                    acc_q <= div_next;
                    cnt_q <= cnt_q + CntW'(1);
                    if (cnt_q == CntW'(WIDTH - 1)) state_q <= StFix;
                end
                StFix: begin
                    Hi      <= fix_hi;
                    Lo      <= fix_lo;
                    Done    <= 1'b1;
                    Busy    <= 1'b0;
                    state_q <= StDone;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: results, latency, Busy/Done shape, ignored issue and reset abort.
module tb_muldiv_unit;

    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MTLO  = 6'h13;

    logic        CLK = 1'b0;
    logic        RST;
    logic        Start;
    logic [5:0]  Funct;
    logic [31:0] Rdata1, Rdata2;
    logic        Busy, Done;
    logic [31:0] Hi, Lo;

    int n_checks = 0;
    int n_errors = 0;

    muldiv_unit dut (
        .CLK    (CLK),
        .RST    (RST),
        .Start  (Start),
        .Funct  (Funct),
        .Rdata1 (Rdata1),
        .Rdata2 (Rdata2),
        .Busy   (Busy),
        .Done   (Done),
        .Hi     (Hi),
        .Lo     (Lo)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; the op is captured at the following posedge (e0).
    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        Start  = 1'b1;
        Funct  = f;
        Rdata1 = a;
        Rdata2 = b;
        @(negedge CLK);
        Start  = 1'b0;
        Funct  = 6'h00;
    endtask

    task automatic wait_done(input int start_lat, output int lat, output int busy_n);
        lat    = start_lat;
        busy_n = 0;
        while (!Done && lat < 100) begin
            if (Busy) busy_n++;
            @(negedge CLK);
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                          input int elat);
        int lat, bn;
        issue(f, a, b);
        wait_done(1, lat, bn);
        check({tag, "_lat"}, 64'(lat), 64'(elat));
        check({tag, "_busy_cycles"}, 64'(bn), 64'(elat - 1));
        check({tag, "_busy_at_done"}, 64'(Busy), 64'(0));
        check({tag, "_hi"}, 64'(Hi), 64'(ehi));
        check({tag, "_lo"}, 64'(Lo), 64'(elo));
        @(negedge CLK);
        check({tag, "_done_pulse"}, 64'(Done), 64'(0));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, bn;
        logic done_seen;
        RST = 1'b1; Start = 1'b0; Funct = 6'h00; Rdata1 = '0; Rdata2 = '0;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        check("rst_hi", 64'(Hi), 64'(0));
        check("rst_lo", 64'(Lo), 64'(0));
        check("rst_busy", 64'(Busy), 64'(0));
        check("rst_done", 64'(Done), 64'(0));

        run_op("mult_7_m3", F_MULT, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 34);
        run_op("multu_max", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 34);
        run_op("divu_100_7", F_DIVU, 32'd100, 32'd7, 32'h2, 32'hE, 34);
        run_op("div_m7_2", F_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34);
        run_op("div_ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 34);
        run_op("divu_by0", F_DIVU, 32'h1234, 32'h0, 32'h1234, 32'hFFFF_FFFF, 2);
        run_op("div_neg_by0", F_DIV, 32'hFFFF_FFF0, 32'h0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 2);

        // Start pulses while busy must be ignored; HI/LO hold until the FIX exit edge.
        issue(F_DIV, 32'd1000, 32'd3);
        repeat (8) @(negedge CLK);
        issue(F_MULT, 32'd9, 32'd9);
        issue(F_MTHI, 32'hDEAD_BEEF, 32'h0);
        check("busy_midop", 64'(Busy), 64'(1));
        check("hold_hi", 64'(Hi), 64'(32'hFFFF_FFF0));
        check("hold_lo", 64'(Lo), 64'(32'hFFFF_FFFF));
        wait_done(11, lat, bn);
        check("ign_lat", 64'(lat), 64'(34));
        check("ign_hi", 64'(Hi), 64'(32'd1));
        check("ign_lo", 64'(Lo), 64'(32'd333));
        @(negedge CLK);
        check("ign_done_pulse", 64'(Done), 64'(0));
        issue(F_MTLO, 32'hA5A5_A5A5, 32'h0);
        check("mtlo_lo", 64'(Lo), 64'(32'hA5A5_A5A5));
        check("mtlo_hi", 64'(Hi), 64'(32'd1));
        check("mtlo_busy", 64'(Busy), 64'(0));
        check("mtlo_done", 64'(Done), 64'(0));

        // Back-to-back: second op issued in the DONE cycle of the first.
        issue(F_MULTU, 32'd3, 32'd5);
        wait_done(1, lat, bn);
        check("b2b_first_lo", 64'(Lo), 64'(32'd15));
        issue(F_MULTU, 32'd6, 32'd7);
        check("b2b_busy", 64'(Busy), 64'(1));
        wait_done(1, lat, bn);
        check("b2b_lat", 64'(lat), 64'(34));
        check("b2b_hi", 64'(Hi), 64'(32'd0));
        check("b2b_lo", 64'(Lo), 64'(32'd42));
        @(negedge CLK);

        // Reset in flight discards the operation.
        issue(F_MTHI, 32'h11, 32'h0);
        check("pre_hi", 64'(Hi), 64'(32'h11));
        issue(F_MTLO, 32'h22, 32'h0);
        check("pre_lo", 64'(Lo), 64'(32'h22));
        issue(F_MULT, 32'd5, 32'd5);
        repeat (13) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("abort_hi", 64'(Hi), 64'(0));
        check("abort_lo", 64'(Lo), 64'(0));
        check("abort_busy", 64'(Busy), 64'(0));
        check("abort_done", 64'(Done), 64'(0));
        done_seen = 1'b0;
        repeat (40) begin
            @(negedge CLK);
            if (Done || Busy) done_seen = 1'b1;
        end
        check("abort_no_done", 64'(done_seen), 64'(0));
        check("abort_hi_after", 64'(Hi), 64'(0));
        check("abort_lo_after", 64'(Lo), 64'(0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
